// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states, frame width,
// and the oversampling counter width helper.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_e;

    // Width of a counter that must hold 0 .. clks_per_bit-1.
    function automatic int cnt_width(input int clks_per_bit);
        return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for asynchronous serial lines. Flops reset to 1 so
// an idle line reads as idle straight out of reset.
module uart_rx_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic meta_q;
        logic sync_q;

        // Two-stage capture of the raw line; the second stage is the only
        // one the rest of the design may look at.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                meta_q <= 1'b1;
                sync_q <= 1'b1;
            end else begin
                meta_q <= d[gi];
                sync_q <= meta_q;
            end
        end

        assign q[gi] = sync_q;
    end

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver, LSB first, oversampled at CLKS_PER_BIT clocks per bit.
// rx_ready is high while a byte is in flight; its falling edge (with the
// byte_vld pulse) marks a new byte on rx_data.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    output logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 byte_vld,
    output logic                 frame_err
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = cnt_width(CLKS_PER_BIT);
    localparam int BW       = $clog2(DATA_BITS);

    // Counter values at which the sample is taken. The counter is cleared on
    // the edge that leaves the previous phase, so it reads N-1 on the N-th
    // edge afterwards.
    localparam logic [CW-1:0] HALF_LAST    = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_IDX_LAST = BW'(DATA_BITS - 1);

    logic rxd_s;

    rx_state_e            state_q,     state_d;
    logic [CW-1:0]        clk_cnt_q,   clk_cnt_d;
    logic [BW-1:0]        bit_cnt_q,   bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q,     shreg_d;
    logic                 rx_ready_q,  rx_ready_d;
    logic [DATA_BITS-1:0] rx_data_q,   rx_data_d;
    logic                 byte_vld_q,  byte_vld_d;
    logic                 frame_err_q, frame_err_d;

    uart_rx_sync #(
        .WIDTH (1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rxd),
        .q     (rxd_s)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            clk_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            rx_ready_q  <= 1'b0;
            rx_data_q   <= '0;
            byte_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            rx_ready_q  <= rx_ready_d;
            rx_data_q   <= rx_data_d;
            byte_vld_q  <= byte_vld_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next-state and output logic: only mid-bit samples of rxd_s matter,
    // everything between sample points is ignored.
    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        rx_ready_d  = rx_ready_q;
        rx_data_d   = rx_data_q;
        byte_vld_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rxd_s) begin
                    state_d   = START;
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                end
            end

            START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = '0;
                    if (!rxd_s) begin
                        state_d    = DATA;
                        rx_ready_d = 1'b1;
                    end else begin
                        // Line went back high before mid start bit: glitch.
                        state_d = IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end

            DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    shreg_d   = {rxd_s, shreg_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == BIT_IDX_LAST) begin
                        state_d = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end

            STOP: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d   = '0;
                    rx_data_d   = shreg_q;
                    rx_ready_d  = 1'b0;
                    byte_vld_d  = 1'b1;
                    frame_err_d = ~rxd_s;
                    // A low stop bit may be a break: wait for the line to
                    // return high before hunting for another start edge.
                    state_d     = rxd_s ? IDLE : WAIT_IDLE;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end

            WAIT_IDLE: begin
                if (rxd_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rx_ready  = rx_ready_q;
    assign rx_data   = rx_data_q;
    assign byte_vld  = byte_vld_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed and randomized bench for uart_rx_byte: one instance at 16 clocks
// per bit, one at 8 clocks per bit driven with bit-period drift.
module tb_uart_rx_byte;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd16 = 1'b1;
    logic       rxd8  = 1'b1;

    logic       rx_ready16, byte_vld16, frame_err16;
    logic [7:0] rx_data16;
    logic       rx_ready8, byte_vld8, frame_err8;
    logic [7:0] rx_data8;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Observed and expected byte streams: {frame_err, data}.
    logic [8:0] obs16[$];
    logic [8:0] obs8[$];
    logic [8:0] exp16[$];
    logic [8:0] exp8[$];

    int   rise16     = 0;
    int   rise_cyc16 = 0;
    int   fall_cyc16 = 0;
    int   bad_evt    = 0;
    logic prev16     = 1'b0;
    logic prev8      = 1'b0;

    uart_rx_byte #(.CLKS_PER_BIT(16)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxd       (rxd16),
        .rx_ready  (rx_ready16),
        .rx_data   (rx_data16),
        .byte_vld  (byte_vld16),
        .frame_err (frame_err16)
    );

    uart_rx_byte #(.CLKS_PER_BIT(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxd       (rxd8),
        .rx_ready  (rx_ready8),
        .rx_data   (rx_data8),
        .byte_vld  (byte_vld8),
        .frame_err (frame_err8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor on the falling edge: collect delivered bytes, rx_ready edges,
    // and any rx_ready fall / frame_err without a byte_vld.
    always @(negedge clk) begin
        if (rst_n) begin
            if (byte_vld16) obs16.push_back({frame_err16, rx_data16});
            if (byte_vld8)  obs8.push_back({frame_err8, rx_data8});
            if (rx_ready16 && !prev16) begin
                rise16     <= rise16 + 1;
                rise_cyc16 <= cyc;
            end
            if (!rx_ready16 && prev16) begin
                fall_cyc16 <= cyc;
                if (!byte_vld16) bad_evt <= bad_evt + 1;
            end
            if (!rx_ready8 && prev8 && !byte_vld8) bad_evt <= bad_evt + 1;
            if ((frame_err16 && !byte_vld16) || (frame_err8 && !byte_vld8))
                bad_evt <= bad_evt + 1;
        end
        prev16 <= rx_ready16;
        prev8  <= rx_ready8;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #2;
    endtask

    // Compare the delivered byte stream of one instance against the model.
    task automatic check_bytes(input string tag, input int sel);
        logic [8:0] o[$];
        logic [8:0] e[$];
        if (sel == 0) begin
            o = obs16; e = exp16; obs16.delete(); exp16.delete();
        end else begin
            o = obs8;  e = exp8;  obs8.delete();  exp8.delete();
        end
        check($sformatf("%s count", tag), 32'(o.size()), 32'(e.size()));
        for (int i = 0; i < e.size() && i < o.size(); i++)
            check($sformatf("%s byte%0d", tag, i), 32'(o[i]), 32'(e[i]));
        $display("%s: %0d bytes compared", tag, e.size());
    endtask

    task automatic drive_bit(input int sel, input logic v, input int n);
        if (sel == 0) rxd16 = v;
        else          rxd8  = v;
        repeat (n) @(negedge clk);
    endtask

    // Serialise one 8N1 frame; with drift, each bit period is cpb +/- 1
    // while the accumulated offset stays within one clock.
    task automatic send_frame(input int sel, input logic [7:0] b, input logic stop_bit,
                              input int cpb, input bit drift);
        logic [9:0] bits;
        int off;
        int p;
        int r;
        bits = {stop_bit, b, 1'b0};
        off  = 0;
        for (int k = 0; k < 10; k++) begin
            p = cpb;
            if (drift) begin
                r = int'($urandom_range(2)) - 1;
                if (off + r >= -1 && off + r <= 1) begin
                    off = off + r;
                    p   = cpb + r;
                end
            end
            drive_bit(sel, bits[k], p);
        end
        if (sel == 0) exp16.push_back({~stop_bit, b});
        else          exp8.push_back({~stop_bit, b});
        $display("sent byte %02h stop=%0b on line %0d", b, stop_bit, sel);
    endtask

    initial begin
        int start_cyc;
        int rise_before;
        logic [7:0] b;

        // Reset state
        repeat (3) @(negedge clk);
        #2;
        check("reset rx_ready",  32'(rx_ready16),  32'h0);
        check("reset rx_data",   32'(rx_data16),   32'h0);
        check("reset byte_vld",  32'(byte_vld16),  32'h0);
        check("reset frame_err", 32'(frame_err16), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_bit(0, 1'b1, 32);

        // 1: single byte, ideal timing, latency check
        start_cyc   = cyc;
        rise_before = rise16;
        send_frame(0, 8'hC0, 1'b1, 16, 1'b0);
        drive_bit(0, 1'b1, 32);
        settle();
        check("t1 rise time", 32'(rise_cyc16), 32'(start_cyc + 11));
        check("t1 fall time", 32'(fall_cyc16), 32'(start_cyc + 155));
        check("t1 rise count", 32'(rise16 - rise_before), 32'd1);
        check_bytes("t1", 0);

        // 2: false start of 4 clocks
        rise_before = rise16;
        drive_bit(0, 1'b0, 4);
        drive_bit(0, 1'b1, 48);
        settle();
        check("t2 no rise", 32'(rise16 - rise_before), 32'd0);
        check("t2 rx_data held", 32'(rx_data16), 32'h0C0);
        check_bytes("t2", 0);

        // 3: back-to-back frame, zero idle
        rise_before = rise16;
        for (int i = 0; i < 3; i++) send_frame(0, 8'hC0, 1'b1, 16, 1'b0);
        for (int i = 0; i < 16; i++) send_frame(0, 8'(i), 1'b1, 16, 1'b0);
        send_frame(0, 8'hCF, 1'b1, 16, 1'b0);
        drive_bit(0, 1'b1, 32);
        settle();
        check("t3 rise count", 32'(rise16 - rise_before), 32'd20);
        check_bytes("t3", 0);

        // 4: framing error followed by a long break, then a good byte
        send_frame(0, 8'h55, 1'b0, 16, 1'b0);
        drive_bit(0, 1'b0, 40 * 16);
        settle();
        check("t4 rx_ready during break", 32'(rx_ready16), 32'h0);
        check_bytes("t4 break", 0);
        drive_bit(0, 1'b1, 32);
        send_frame(0, 8'hA3, 1'b1, 16, 1'b0);
        drive_bit(0, 1'b1, 32);
        settle();
        check_bytes("t4 recover", 0);

        // 5: reset in the middle of data bit 4 of 8'hFF
        drive_bit(0, 1'b0, 16);
        for (int i = 0; i < 4; i++) drive_bit(0, 1'b1, 16);
        drive_bit(0, 1'b1, 8);
        check("t5 in flight", 32'(rx_ready16), 32'h1);
        rst_n = 1'b0;
        #1;
        check("t5 async rx_ready",  32'(rx_ready16),  32'h0);
        check("t5 async rx_data",   32'(rx_data16),   32'h0);
        check("t5 async byte_vld",  32'(byte_vld16),  32'h0);
        check("t5 async frame_err", 32'(frame_err16), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        drive_bit(0, 1'b1, 32);
        send_frame(0, 8'h3C, 1'b1, 16, 1'b0);
        drive_bit(0, 1'b1, 32);
        settle();
        check_bytes("t5", 0);

        // Random bytes with random idle gaps on the 16x instance
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            send_frame(0, b, 1'b1, 16, 1'b0);
            drive_bit(0, 1'b1, int'($urandom_range(20)));
        end
        drive_bit(0, 1'b1, 32);
        settle();
        check_bytes("random16", 0);

        // 6: 8x instance with +/-1 clock drift
        send_frame(1, 8'h96, 1'b1, 8, 1'b1);
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            send_frame(1, b, 1'b1, 8, 1'b1);
            drive_bit(1, 1'b1, int'($urandom_range(6)));
        end
        drive_bit(1, 1'b1, 24);
        settle();
        check_bytes("t6 drift", 1);

        check("no rx_ready fall without byte_vld", 32'(bad_evt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
Asynchronous serial receiver: 8 data bits, no parity, 1 stop bit, LSB first. It oversamples the RS232 RX line at CLKS_PER_BIT clocks per bit and delivers each received byte as rx_data. rx_ready is high while a byte is in flight; its falling edge marks a new byte. This block sits directly upstream of the command-frame decoder, which parses C0 C0 C0 / 16 data bytes / CF frames from that falling edge.

Parameters:
CLKS_PER_BIT, 16, clk cycles per bit period; integer, >= 4. Counter width is $clog2(CLKS_PER_BIT).
HALF_BIT, CLKS_PER_BIT/2, cycles from start-edge detection to the mid-start-bit sample; derived, not overridden.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
rxd  input  1  raw serial line, asynchronous to clk; idle high
rx_ready  output  1  high from confirmed start bit until stop-bit sample; falling edge = new byte
rx_data  output  8  last received byte; held until the next stop-bit sample
byte_vld  output  1  one-cycle pulse, coincident with rx_ready falling
frame_err  output  1  one-cycle pulse with byte_vld when the stop bit sampled 0

Behaviour:
- Reset values: rx_ready=0, rx_data=8'h00, byte_vld=0, frame_err=0, state=IDLE, counters=0. Synchroniser flops reset to 1 (line idle).
- rxd passes through a 2-flop synchroniser giving rxd_s. All logic uses rxd_s only.
- Let t0 be the clock edge at which IDLE first sees rxd_s=0.
- State IDLE: on rxd_s=0, go to START and clear bit_cnt and clk_cnt.
- State START: sample at t0+HALF_BIT.
  - rxd_s=0: go to DATA and set rx_ready=1 on that edge.
  - rxd_s=1: false start; return to IDLE, rx_ready stays 0, no outputs change.
- State DATA: data bit i (i=0..7) is sampled at t0+HALF_BIT+(i+1)*CLKS_PER_BIT and shifted into shreg[i] (LSB first). After bit 7, go to STOP.
- State STOP: sample at t0+HALF_BIT+9*CLKS_PER_BIT. On that edge:
  - rx_data <= shreg
  - rx_ready <= 0
  - byte_vld <= 1 for one cycle
  - frame_err <= ~rxd_s for one cycle
  - Stop bit = 1: next state IDLE. A new start edge can be detected from the following cycle, so back-to-back bytes with zero idle are received.
  - Stop bit = 0: next state WAIT_IDLE.
- State WAIT_IDLE (framing error or break): stay until rxd_s=1, then IDLE. rx_ready stays 0 and no further bytes are delivered while the line is held low.
- A framing-error byte is still delivered (rx_data updated, rx_ready falls). The consumer discards it via its own frame check or via frame_err.
- Latency for CLKS_PER_BIT=16: rx_ready rises at t0+8 and falls at t0+152; t0 trails the raw rxd edge by 2 clocks.
- rx_ready never falls without a byte_vld pulse, and never rises on a false start.
- Reset mid-byte: everything returns to reset values immediately; a partial byte is dropped without any byte_vld.
- rxd is ignored in STOP, except the single stop sample.
- rxd changes between sample points (glitches) are ignored; only mid-bit samples count.

Decomposition:
- Shared package uart_pkg holds:
  - state enum: IDLE, START, DATA, STOP, WAIT_IDLE
  - DATA_BITS=8
  - a function computing counter width from CLKS_PER_BIT
- One sub-module, uart_rx_sync: the 2-flop synchroniser with reset value 1. It is reused by the other RX-line inputs of the rf_ctr block.

Test Plan:
1. CLKS_PER_BIT=16; send 8'hC0 with ideal timing -> rx_ready rises at t0+8 and falls at t0+152; rx_data=8'hC0; one byte_vld pulse; frame_err=0.
2. Pull rxd low for 4 clocks, then high -> no rx_ready rise, no byte_vld, rx_data unchanged, returns to IDLE.
3. Back-to-back with zero idle: C0 C0 C0, bytes 00..0F, then CF -> 20 byte_vld pulses in order with matching rx_data; downstream decoder outputs 128'h000102...0F once.
4. Send 8'h55 with stop bit 0, then hold rxd low for 40 bit periods -> one byte_vld with frame_err=1 and rx_data=8'h55; nothing more until rxd goes high. A following 8'hA3 is then received correctly.
5. Assert rst_n low at data bit 4 of 8'hFF -> all outputs 0 immediately; after release, 8'h3C is received with no spurious byte_vld.
6. CLKS_PER_BIT=8; transmitter bit period 8 clocks ±1 clock drift over the frame -> 8'h96 received correctly, frame_err=0.
